mem_bist_master: RTL and testbench

- Initiator for the team's valid/ready single-port memory (wr_rd, addr, wdata, rdata, valid, ready).
- On start, writes a generated pattern to every address 0..DEPTH-1, then reads each address back and compares against the expected pattern.
- Reports pass/fail, error count, first failing address and timeout.
- Sits between the test/config controller and the memory; drives the memory's request side directly.

---
 rtl/mem_bist_pkg.sv | 27 ++
 rtl/mem_bist_pattern_gen.sv | 25 ++
 rtl/mem_bist_master.sv | 214 +++++++++++++++++++++
 tb/tb_mem_bist_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST initiator. The inverted second pass is enabled
// by defining MEM_BIST_INV_PASS_EN.
package mem_bist_pkg;

  typedef enum logic {
    PAT_CONST = 1'b0,
    PAT_INC   = 1'b1
  } pat_sel_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [3:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
`ifdef MEM_BIST_INV_PASS_EN
    StWriReq,
    StWriWait,
    StRdiReq,
    StRdiWait,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/mem_bist_pattern_gen.sv
// Combinational test pattern: seed, or seed + addr (carry discarded), optionally inverted.
module mem_bist_pattern_gen
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic [WIDTH-1:0]      seed,
  input  logic                  pattern_sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  invert,
  output logic [WIDTH-1:0]      pattern
);

  logic [WIDTH-1:0] base;

  always_comb begin
    base = seed;
    if (pattern_sel == PAT_INC) begin
      base = seed + WIDTH'(addr);
    end
    pattern = invert ? ~base : base;
  end

endmodule

// File: rtl/mem_bist_master.sv
// Write-then-read-back BIST initiator for the valid/ready single-port memory.
// Defining MEM_BIST_INV_PASS_EN adds a second write/read pass with inverted data.
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pattern_sel,
  input  logic [WIDTH-1:0]      seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_err,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic                  m_ready
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic                  sel_q, sel_d;
  logic [ADDR_WIDTH:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic                  tout_q, tout_d;
  logic                  pass_q, pass_d;

  logic             in_wait;
  logic             invert;
  logic             last;
  logic             mismatch;
  logic [WIDTH-1:0] pattern;

  mem_bist_pattern_gen #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pattern_gen (
    .seed        (seed_q),
    .pattern_sel (sel_q),
    .addr        (addr_q),
    .invert      (invert),
    .pattern     (pattern)
  );

  assign last     = (addr_q == LastAddr);
  assign mismatch = (m_rdata != pattern);

  always_comb begin
    m_valid = 1'b0;
    m_wr_rd = 1'b0;
    invert  = 1'b0;
    in_wait = 1'b0;
    unique case (state_q)
      StWrReq:   begin m_valid = 1'b1; m_wr_rd = 1'b1; end
      StWrWait:  begin m_wr_rd = 1'b1; in_wait = 1'b1; end
      StRdReq:   m_valid = 1'b1;
      StRdWait:  in_wait = 1'b1;
`ifdef MEM_BIST_INV_PASS_EN
      StWriReq:  begin m_valid = 1'b1; m_wr_rd = 1'b1; invert = 1'b1; end
      StWriWait: begin m_wr_rd = 1'b1; in_wait = 1'b1; invert = 1'b1; end
      StRdiReq:  begin m_valid = 1'b1; invert = 1'b1; end
      StRdiWait: begin in_wait = 1'b1; invert = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    seed_d  = seed_q;
    sel_d   = sel_q;
    err_d   = err_q;
    first_d = first_q;
    tout_d  = tout_q;
    pass_d  = pass_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d  = seed;
          sel_d   = pattern_sel;
          err_d   = '0;
          first_d = '0;
          tout_d  = 1'b0;
          pass_d  = 1'b0;
          addr_d  = '0;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        wait_d  = '0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (m_ready) begin
          addr_d  = last ? '0 : addr_q + 1'b1;
          state_d = last ? StRdReq : StWrReq;
        end
      end
      StRdReq: begin
        wait_d  = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (m_ready) begin
          if (mismatch) begin
            if (err_q == '0) first_d = addr_q;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          addr_d = last ? '0 : addr_q + 1'b1;
`ifdef MEM_BIST_INV_PASS_EN
          state_d = last ? StWriReq : StRdReq;
`else
          state_d = last ? StDone : StRdReq;
`endif
        end
      end
`ifdef MEM_BIST_INV_PASS_EN
      StWriReq: begin
        wait_d  = '0;
        state_d = StWriWait;
      end
      StWriWait: begin
        if (m_ready) begin
          addr_d  = last ? '0 : addr_q + 1'b1;
          state_d = last ? StRdiReq : StWriReq;
        end
      end
      StRdiReq: begin
        wait_d  = '0;
        state_d = StRdiWait;
      end
      StRdiWait: begin
        if (m_ready) begin
          if (mismatch) begin
            if (err_q == '0) first_d = addr_q;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
          addr_d  = last ? '0 : addr_q + 1'b1;
          state_d = last ? StDone : StRdiReq;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (in_wait && !m_ready) begin
      if (wait_q == WaitLimit) begin
        tout_d  = 1'b1;
        state_d = StDone;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    // Verdict is taken on entry to DONE so a mismatch on the final read is included.
    if (state_d == StDone && state_q != StDone) begin
      pass_d = (err_d == '0) && !tout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wait_q  <= '0;
      seed_q  <= '0;
      sel_q   <= PAT_CONST;
      err_q   <= '0;
      first_q <= '0;
      tout_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      seed_q  <= seed_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      first_q <= first_d;
      tout_q  <= tout_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign timeout_err    = tout_q;
  assign m_addr         = addr_q;
  assign m_wdata        = pattern;

endmodule

// File: tb/tb_mem_bist_master.sv
// Directed bench for mem_bist_master with a registered memory model and write scoreboard.
module tb_mem_bist_master;

`ifdef MEM_BIST_INV_PASS_EN
  localparam int Passes = 2;
`else
  localparam int Passes = 1;
`endif
  localparam int RunCycles = 4 * 16 * Passes + 1;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pattern_sel;
  logic [7:0] seed;
  logic       busy, done, pass, timeout_err;
  logic [4:0] err_count;
  logic [3:0] first_err_addr;
  logic       m_valid, m_wr_rd;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic       m_ready;

  logic [7:0] mem  [16];
  logic [7:0] flip [16];
  logic       hang_en;
  logic       stuck_en;
  int         wr_cnt;

  int  total = 0;
  int  bad = 0;
  wr_t exp_q[$];

  mem_bist_master #(
    .WIDTH   (8),
    .DEPTH   (16),
    .TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout_err    (timeout_err),
    .m_valid        (m_valid),
    .m_wr_rd        (m_wr_rd),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_rdata        (m_rdata),
    .m_ready        (m_ready)
  );

  always #5 clk = ~clk;

  // Memory: acknowledge registered one cycle after valid; read faults injected on the way out.
  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_rdata <= 8'h00;
      wr_cnt  <= 0;
    end else begin
      if (start) wr_cnt <= 0;
      m_ready <= 1'b0;
      if (m_valid) begin
        if (m_wr_rd) begin
          mem[m_addr] <= m_wdata;
          wr_cnt      <= wr_cnt + 1;
          m_ready     <= !(hang_en && wr_cnt >= 2);
        end else begin
          m_rdata <= (mem[m_addr] ^ flip[m_addr]) |
                     ((stuck_en && m_addr == 4'd3) ? 8'h01 : 8'h00);
          m_ready <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_first"}, first_err_addr, 0);
    check({tag, "_tout"}, timeout_err, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_wr_rd"}, m_wr_rd, 0);
    check({tag, "_addr"}, m_addr, 0);
    check({tag, "_wdata"}, m_wdata, 0);
  endtask

  function automatic logic [7:0] model_pat(input logic [7:0] sd, input logic sel, input int a);
    logic [7:0] p;
    p = sel ? sd + 8'(a) : sd;
    return p;
  endfunction

  task automatic start_run(input logic [7:0] sd, input logic sel);
    exp_q.delete();
    for (int p = 0; p < Passes; p++) begin
      for (int a = 0; a < 16; a++) begin
        wr_t e;
        e.addr = a;
        e.data = (p == 1) ? ~model_pat(sd, sel, a) : model_pat(sd, sel, a);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    seed        = sd;
    pattern_sel = sel;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps negedge by negedge from the first post-start cycle until done, checking writes.
  task automatic run_to_done(input int budget, input int poke_cyc, input bit poke_done,
                             output int cyc, output int nvalid, output int nwr);
    bit  seen;
    wr_t e;
    cyc    = 1;
    nvalid = 0;
    nwr    = 0;
    seen   = 1'b0;
    while (!seen && cyc <= budget) begin
      if (m_valid) begin
        nvalid++;
        if (m_wr_rd) begin
          nwr++;
          if (exp_q.size() == 0) begin
            check("wr_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", m_addr, e.addr);
            check("wr_data", m_wdata, e.data);
          end
        end
      end
      if (cyc == poke_cyc) begin
        start = 1'b1;
        seed  = 8'h3C;
      end else if (cyc == poke_cyc + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        if (poke_done) start = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", seen, 1);
  endtask

  initial begin
    int  cyc, nvalid, nwr;
    bit  found;
    rst         = 1'b1;
    start       = 1'b0;
    pattern_sel = 1'b0;
    seed        = 8'h00;
    hang_en     = 1'b0;
    stuck_en    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      flip[i] = 8'h00;
      mem[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Incrementing pattern with wrap past FF.
    start_run(8'hF8, 1'b1);
    run_to_done(400, 0, 1'b0, cyc, nvalid, nwr);
    check("inc_cycles", cyc, RunCycles);
    check("inc_nvalid", nvalid, 32 * Passes);
    check("inc_left", exp_q.size(), 0);
    check("inc_pass", pass, 1);
    check("inc_err", err_count, 0);
    check("inc_tout", timeout_err, 0);

    // Read faults at addresses 5 and 9.
    flip[5] = 8'h01;
    flip[9] = 8'h80;
    start_run(8'hA5, 1'b0);
    run_to_done(400, 0, 1'b0, cyc, nvalid, nwr);
    check("corr_cycles", cyc, RunCycles);
    check("corr_pass", pass, 0);
    check("corr_err", err_count, 2 * Passes);
    check("corr_first", first_err_addr, 5);
    check("corr_tout", timeout_err, 0);
    flip[5] = 8'h00;
    flip[9] = 8'h00;

    // Memory stops acknowledging from the third write.
    hang_en = 1'b1;
    start_run(8'h42, 1'b1);
    run_to_done(100, 0, 1'b0, cyc, nvalid, nwr);
    check("tout_cycles", cyc, 21);
    check("tout_nwr", nwr, 3);
    check("tout_flag", timeout_err, 1);
    check("tout_pass", pass, 0);
    check("tout_err", err_count, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("tout_valid_quiet", m_valid, 0);
    end
    hang_en = 1'b0;
    exp_q.delete();

    // Reset in RD_WAIT of address 7, then a clean run.
    start_run(8'h11, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_valid && !m_wr_rd && m_addr == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("rd7_seen", found, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    start_run(8'h11, 1'b1);
    run_to_done(400, 0, 1'b0, cyc, nvalid, nwr);
    check("postrst_cycles", cyc, RunCycles);
    check("postrst_pass", pass, 1);

    // start while busy (with a seed change) and on the DONE cycle are both ignored.
    start_run(8'h5A, 1'b1);
    run_to_done(400, 10, 1'b1, cyc, nvalid, nwr);
    check("ign_cycles", cyc, RunCycles);
    check("ign_left", exp_q.size(), 0);
    @(negedge clk);
    start = 1'b0;
    check("ign_busy_after_done", busy, 0);
    check("ign_pass_held", pass, 1);
    @(negedge clk);
    check("ign_busy_idle", busy, 0);

`ifdef MEM_BIST_INV_PASS_EN
    // Stuck-at-1 bit 0 at address 3 only shows against the all-zero pass.
    stuck_en = 1'b1;
    start_run(8'h00, 1'b0);
    run_to_done(400, 0, 1'b0, cyc, nvalid, nwr);
    check("stuck_cycles", cyc, 129);
    check("stuck_err", err_count, 1);
    check("stuck_first", first_err_addr, 3);
    check("stuck_pass", pass, 0);
    stuck_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
